btn_pulse: RTL and testbench

BTN_PULSE -- requirements
Module: btn_pulse

---
 rtl/btn_pulse.sv | 87 ++++++++
 tb/tb_btn_pulse.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/btn_pulse.sv
// Dual-channel pushbutton conditioner: optional two-flop synchronizer, counter-based
// debouncer and a registered single-cycle press pulse per channel.
// Channel 0: btn_trig_raw -> trig, channel 1: btn_split_raw -> split.
// Optional feature: define BTN_SYNC_EN to insert the two-flop synchronizers
// (leave undefined only for simulation; it removes 2 cycles of latency).

module btn_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_trig_raw,
   input  logic btn_split_raw,
   output logic trig,
   output logic split
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0] raw;
   logic [1:0] din;
   logic [1:0] pulse;

   assign raw = {btn_split_raw, btn_trig_raw};

`ifdef BTN_SYNC_EN
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;

   // Two-flop synchronizer for both asynchronous button pins
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign din = sync2_q;
`else
   assign din = raw;
`endif

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic          stable_q, stable_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          pulse_q, pulse_d;

      // Debounce next state: count while din disagrees with stable, accept at CNT_MAX
      always_comb begin
         stable_d = stable_q;
         cnt_d    = '0;
         pulse_d  = 1'b0;
         if (din[ch] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
               stable_d = din[ch];
               // Pulse only on an accepted press, never on a release
               pulse_d  = din[ch];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // Channel state registers
      always_ff @(posedge clk) begin
         if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
         end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
         end
      end

      assign pulse[ch] = pulse_q;
   end

   assign trig  = pulse[0];
   assign split = pulse[1];

endmodule

// File: tb/tb_btn_pulse.sv
// Self-checking bench for btn_pulse with DEBOUNCE_CYCLES=4 and a 10 ns clock.
// Expected pulse cycles are queued when stimulus is driven and compared every cycle.

module tb_btn_pulse;

   localparam int unsigned DC = 4;
`ifdef BTN_SYNC_EN
   localparam int LAT = DC + 1;
`else
   localparam int LAT = DC - 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_trig_raw = 1'b0;
   logic btn_split_raw = 1'b0;
   logic trig;
   logic split;

   btn_pulse #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_trig_raw (btn_trig_raw),
      .btn_split_raw(btn_split_raw),
      .trig         (trig),
      .split        (split)
   );

   always #5 clk = ~clk;

   int ncyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int q_trig[$];
   int q_split[$];

   // Minimal stopwatch-controller model driven by the pulses
   logic ctl_run;
   logic ctl_init_seen;
   always_ff @(posedge clk) begin
      if (reset) begin
         ctl_run       <= 1'b0;
         ctl_init_seen <= 1'b0;
      end else begin
         if (trig) ctl_run <= ~ctl_run;
         if (split && !ctl_run) ctl_init_seen <= 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, ncyc, got, exp);
   endtask

   // Advance one cycle; compare both outputs against the scoreboard at the negedge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         logic exp_t, exp_s;
         @(posedge clk);
         ncyc++;
         @(negedge clk);
         exp_t = (q_trig.size() != 0) && (q_trig[0] == ncyc);
         exp_s = (q_split.size() != 0) && (q_split[0] == ncyc);
         if (exp_t) void'(q_trig.pop_front());
         if (exp_s) void'(q_split.pop_front());
         check_eq("trig", {31'b0, trig}, {31'b0, exp_t});
         check_eq("split", {31'b0, split}, {31'b0, exp_s});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      tick(3);

      // Clean press held 20 cycles, then release (release must not pulse)
      btn_trig_raw = 1'b1;
      q_trig.push_back(ncyc + LAT + 1);
      tick(20);
      btn_trig_raw = 1'b0;
      tick(10);

      // Bounce 1,0,1,0 then held high
      for (int i = 0; i < 4; i++) begin
         btn_trig_raw = (i % 2 == 0);
         tick(1);
      end
      btn_trig_raw = 1'b1;
      q_trig.push_back(ncyc + LAT + 1);
      tick(20);
      btn_trig_raw = 1'b0;
      tick(10);

      // 3-cycle glitch on split: never accepted
      btn_split_raw = 1'b1;
      tick(3);
      btn_split_raw = 1'b0;
      tick(10);

      // Simultaneous presses
      btn_trig_raw  = 1'b1;
      btn_split_raw = 1'b1;
      q_trig.push_back(ncyc + LAT + 1);
      q_split.push_back(ncyc + LAT + 1);
      tick(15);
      btn_trig_raw  = 1'b0;
      btn_split_raw = 1'b0;
      tick(10);

      // Reset at the fourth edge of a press; held button pulses once after reset falls
      btn_trig_raw = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      q_trig.push_back(ncyc + LAT + 1);
      tick(15);
      btn_trig_raw = 1'b0;
      tick(10);

      // Integration with controller model
      do_reset();
      tick(2);
      check_eq("ctl_run_reset", {31'b0, ctl_run}, 32'd0);
      for (int p = 0; p < 2; p++) begin
         btn_trig_raw = 1'b1;
         q_trig.push_back(ncyc + LAT + 1);
         tick(12);
         btn_trig_raw = 1'b0;
         tick(10);
         check_eq("ctl_run", {31'b0, ctl_run}, (p == 0) ? 32'd1 : 32'd0);
      end
      check_eq("ctl_init_before", {31'b0, ctl_init_seen}, 32'd0);
      btn_split_raw = 1'b1;
      q_split.push_back(ncyc + LAT + 1);
      tick(12);
      btn_split_raw = 1'b0;
      tick(10);
      check_eq("ctl_init", {31'b0, ctl_init_seen}, 32'd1);
      check_eq("ctl_run_after_init", {31'b0, ctl_run}, 32'd0);

      check_eq("trig_pending", q_trig.size(), 32'd0);
      check_eq("split_pending", q_split.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
